// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared constants and types for the pipeline hazard controller
// Purpose : register index width, hazard FSM state encoding, NOP instruction encoding.
// Ports   : none (package).
package pipeline_pkg;

  localparam int REG_AW = 4;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } hz_state_e;

  // Encoding loaded into a cleared pipeline register (all-zero word).
  localparam logic [15:0] NOP_INSTR = 16'h0000;

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// rtl/pipeline_hazard_controller_if.sv - hazard sense inputs and pipeline control outputs
// Purpose : bundles the decode/EX/MEM sense signals and the stall/flush/freeze controls.
// Ports   : master - drives sense signals, receives controls (pipeline side)
//           slave  - receives sense signals, drives controls (hazard controller)
interface pipeline_hazard_controller_if #(
  parameter int REG_AW = pipeline_pkg::REG_AW
);
  logic              Read_Enable_1_ID;
  logic [REG_AW-1:0] rs1_ID;
  logic              Read_Enable_2_ID;
  logic [REG_AW-1:0] rs2_ID;
  logic              Write_Enable_EX;
  logic [REG_AW-1:0] rd_EX;
  logic              Mem_Read_EX;
  logic              Branch_Taken_EX;
  logic              Mem_Req_MEM;
  logic              Mem_Ready_MEM;
  logic              Stall_IF;
  logic              Stall_ID;
  logic              Bubble_EX;
  logic              Flush_IF_ID;
  logic              Flush_ID_EX;
  logic              Freeze;
  logic              Halt;

  modport master (
    output Read_Enable_1_ID, rs1_ID, Read_Enable_2_ID, rs2_ID,
    output Write_Enable_EX, rd_EX, Mem_Read_EX, Branch_Taken_EX,
    output Mem_Req_MEM, Mem_Ready_MEM,
    input  Stall_IF, Stall_ID, Bubble_EX, Flush_IF_ID, Flush_ID_EX, Freeze, Halt
  );

  modport slave (
    input  Read_Enable_1_ID, rs1_ID, Read_Enable_2_ID, rs2_ID,
    input  Write_Enable_EX, rd_EX, Mem_Read_EX, Branch_Taken_EX,
    input  Mem_Req_MEM, Mem_Ready_MEM,
    output Stall_IF, Stall_ID, Bubble_EX, Flush_IF_ID, Flush_ID_EX, Freeze, Halt
  );
endinterface

// File: rtl/hazard_perf_counter.sv
// rtl/hazard_perf_counter.sv - saturating event counter for hazard statistics
// Purpose : counts cycles with i_inc high, sticks at all-ones, cleared by rst.
//           Only built when HAZARD_PERF_CNT_EN is defined.
// Ports   : clk, rst (sync active-high), i_inc event strobe, o_cnt count value.
`ifdef HAZARD_PERF_CNT_EN
module hazard_perf_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
endmodule
`endif

// File: rtl/pipeline_hazard_controller.sv
// rtl/pipeline_hazard_controller.sv - load-use stall, branch flush and memory freeze/halt control
// Purpose : drives enable/clear controls of the 5-stage pipeline registers. Stalls one
//           cycle on a load-use hazard, flushes IF/ID and ID/EX on a taken branch,
//           freezes the pipe while data memory is busy, halts on a memory timeout.
// Ports   : clk, rst (sync active-high); hz_if (slave) sense inputs and control outputs;
//           Load_Stall_Cnt, Flush_Cnt, Mem_Wait_Cnt only when HAZARD_PERF_CNT_EN is defined.
// Macro   : HAZARD_PERF_CNT_EN - adds the three saturating performance counters.
module pipeline_hazard_controller
  import pipeline_pkg::*;
#(
  parameter int REG_AW      = pipeline_pkg::REG_AW,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  pipeline_hazard_controller_if.slave   hz_if
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]              Load_Stall_Cnt,
  output logic [CNT_W-1:0]              Flush_Cnt,
  output logic [CNT_W-1:0]              Mem_Wait_Cnt
`endif
);

  localparam logic [1:0] S_RUN      = RUN;
  localparam logic [1:0] S_MEM_WAIT = MEM_WAIT;
  localparam logic [1:0] S_ERROR    = ERROR;

  // Wide enough to hold MEM_TIMEOUT itself; the counter stops there.
  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

  logic [1:0]      r_state;
  logic [WC_W-1:0] r_wait_cnt;

  logic w_mem_pending;
  logic w_load_use;
  logic w_freeze;
  logic w_flush;
  logic w_stall;

  assign w_mem_pending = hz_if.Mem_Req_MEM & ~hz_if.Mem_Ready_MEM;

  // Loads cannot forward to the very next instruction; r0 never creates a dependency.
  assign w_load_use = hz_if.Mem_Read_EX & hz_if.Write_Enable_EX &
                      (hz_if.rd_EX != REG_AW'(0)) &
                      ((hz_if.Read_Enable_1_ID & (hz_if.rs1_ID == hz_if.rd_EX)) |
                       (hz_if.Read_Enable_2_ID & (hz_if.rs2_ID == hz_if.rd_EX)));

  assign w_freeze = (r_state == S_ERROR) | w_mem_pending;

  // Freeze masks everything so a held branch/hazard is acted on once the pipe moves.
  // A taken branch wins over load-use: the decode instruction is wrong-path anyway.
  assign w_flush = hz_if.Branch_Taken_EX & ~w_freeze;
  assign w_stall = w_load_use & ~w_freeze & ~hz_if.Branch_Taken_EX;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_RUN;
      r_wait_cnt <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_mem_pending) begin
            r_state    <= S_MEM_WAIT;
            r_wait_cnt <= WC_W'(1);
          end
        end
        S_MEM_WAIT: begin
          if (hz_if.Mem_Ready_MEM) begin
            r_state <= S_RUN;
          end else if (r_wait_cnt == WC_W'(MEM_TIMEOUT)) begin
            r_state <= S_ERROR;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        S_ERROR: begin
          r_state <= S_ERROR;
        end
        default: begin
          r_state <= S_ERROR;
        end
      endcase
    end
  end

  // While rst is high the pipe is held cleared regardless of the registered state.
  always_comb begin
    hz_if.Stall_IF    = 1'b0;
    hz_if.Stall_ID    = 1'b0;
    hz_if.Bubble_EX   = 1'b0;
    hz_if.Flush_IF_ID = 1'b1;
    hz_if.Flush_ID_EX = 1'b1;
    hz_if.Freeze      = 1'b0;
    hz_if.Halt        = 1'b0;
    if (!rst) begin
      hz_if.Stall_IF    = w_stall;
      hz_if.Stall_ID    = w_stall;
      hz_if.Bubble_EX   = w_stall;
      hz_if.Flush_IF_ID = w_flush;
      hz_if.Flush_ID_EX = w_flush;
      hz_if.Freeze      = w_freeze;
      hz_if.Halt        = (r_state == S_ERROR);
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_counter #(.CNT_W(CNT_W)) u_load_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (hz_if.Bubble_EX),
    .o_cnt (Load_Stall_Cnt)
  );

  hazard_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (hz_if.Flush_IF_ID),
    .o_cnt (Flush_Cnt)
  );

  hazard_perf_counter #(.CNT_W(CNT_W)) u_mem_wait_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (hz_if.Freeze),
    .o_cnt (Mem_Wait_Cnt)
  );
`else
  logic [CNT_W-1:0] w_perf_unused;
  assign w_perf_unused = '0;
`endif

endmodule
